uart_tx_fwft: RTL and testbench

//  UART transmit serializer. Sits directly downstream of the 2-word FWFT FIFO
//  and pops bytes from it: fifo_not_empty/data_out feed it; it drives shift_out.

---
 rtl/uart_tx_fwft.sv | 137 +++++++++++++
 tb/tb_uart_tx_fwft.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fwft.sv
// UART transmit serializer popping words from a first-word-fall-through FIFO.
// Frame: start bit, BITS data bits LSB first, optional parity, STOP_BITS stop bits.
// When the FIFO still holds a word at the end of the last stop bit, the next
// frame starts on the following clock with no idle bit in between.
//
// Ports:
//   clk             system clock, rising edge
//   reset           asynchronous active-low reset (0 = in reset)
//   fifo_not_empty  FIFO output word valid
//   fifo_data       FIFO output word
//   fifo_shift_out  one-cycle pop strobe to the FIFO (combinational)
//   tx              serial line, idle high (registered)
//   busy            high while any frame bit is on tx (registered)
module uart_tx_fwft #(
  parameter int unsigned BITS         = 8,
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fifo_not_empty,
  input  logic [BITS-1:0] fifo_data,
  output logic            fifo_shift_out,
  output logic            tx,
  output logic            busy
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  // Shared index for data bits and stop bits; BITS >= 5 so it also covers STOP_BITS-1.
  localparam int unsigned IDX_W  = $clog2(BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e            state_q;
  logic [BAUD_W-1:0] baud_q;
  logic [IDX_W-1:0]  idx_q;
  logic [BITS-1:0]   shreg_q;
  logic              par_q;
  logic              tx_q;
  logic              busy_q;

  logic bit_end;
  logic last_data;
  logic last_stop;
  logic take;

  assign bit_end   = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  assign last_data = (idx_q == IDX_W'(BITS - 1));
  assign last_stop = (idx_q == IDX_W'(STOP_BITS - 1));

  // Accept a word when idle, or exactly at the end of the final stop bit so
  // the next start bit follows without a gap. Gated by reset so no pop leaks
  // out while the block is held in reset.
  assign take = reset && fifo_not_empty &&
                ((state_q == S_IDLE) ||
                 ((state_q == S_STOP) && bit_end && last_stop));

  assign fifo_shift_out = take;
  assign tx             = tx_q;
  assign busy           = busy_q;

  // Frame sequencer; tx/busy are loaded with the value of the bit that starts
  // on this edge, so they change glitch-free exactly on bit boundaries.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else if (take) begin
      state_q <= S_START;
      baud_q  <= '0;
      idx_q   <= '0;
      shreg_q <= fifo_data;
      par_q   <= (PARITY == 1) ? ~^fifo_data : ^fifo_data;
      tx_q    <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      if (state_q != S_IDLE) begin
        baud_q <= bit_end ? '0 : baud_q + 1'b1;
      end
      if (bit_end) begin
        case (state_q)
          S_START: begin
            state_q <= S_DATA;
            idx_q   <= '0;
            tx_q    <= shreg_q[0];
          end
          S_DATA: begin
            shreg_q <= shreg_q >> 1;
            if (last_data) begin
              idx_q <= '0;
              if (PARITY != 0) begin
                state_q <= S_PARITY;
                tx_q    <= par_q;
              end else begin
                state_q <= S_STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              idx_q <= idx_q + 1'b1;
              tx_q  <= shreg_q[1];
            end
          end
          S_PARITY: begin
            state_q <= S_STOP;
            idx_q   <= '0;
            tx_q    <= 1'b1;
          end
          S_STOP: begin
            // The no-gap restart is handled by the take branch above.
            if (last_stop) begin
              state_q <= S_IDLE;
              idx_q   <= '0;
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fwft.sv
// Testbench for uart_tx_fwft. Four transmitters run side by side with
// different parameter sets, each fed by a 2-word FWFT FIFO model from a
// per-lane word script and watched by a UART frame decoder.
//   lane 0: CLKS_PER_BIT=4,   no parity,   1 stop
//   lane 1: CLKS_PER_BIT=4,   even parity, 2 stop
//   lane 2: CLKS_PER_BIT=4,   odd parity,  1 stop
//   lane 3: CLKS_PER_BIT=217, no parity,   1 stop
module tb_uart_tx_fwft;

  localparam int NL = 4;

  function automatic int lane_clk(input int g);
    case (g)
      3:       return 217;
      default: return 4;
    endcase
  endfunction

  function automatic int lane_par(input int g);
    case (g)
      1:       return 2;
      2:       return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int lane_stop(input int g);
    case (g)
      1:       return 2;
      default: return 1;
    endcase
  endfunction

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT-facing signals
  logic       ne   [NL];
  logic [7:0] fd   [NL];
  logic       pop  [NL];
  logic       tx   [NL];
  logic       busy [NL];

  // Stimulus scripts (written only by the main initial block)
  logic [7:0] words   [NL][256];
  int         avail   [NL][256];
  int         n_words [NL];

  // FIFO model state
  logic [7:0] fmem   [NL][2];
  int         fcnt   [NL];
  logic       frd    [NL];
  int         wr_idx [NL];
  int         pops   [NL];
  logic [7:0] junk   [NL];

  // Monitor state
  logic in_fr    [NL];
  int   off      [NL];
  logic bitv     [NL][16];
  int   mon_idx  [NL];
  int   busy_cnt [NL];
  int   b2b      [NL];
  logic just_end [NL];
  logic pop_pend [NL];
  int   pop_gap  [NL];
  int   last_pop [NL];
  logic par_last [NL];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < NL; g++) begin : g_lane
    assign ne[g] = (fcnt[g] != 0);
    assign fd[g] = (fcnt[g] != 0) ? fmem[g][frd[g]] : junk[g];

    uart_tx_fwft #(
      .BITS         (8),
      .CLKS_PER_BIT (lane_clk(g)),
      .PARITY       (lane_par(g)),
      .STOP_BITS    (lane_stop(g))
    ) u_dut (
      .clk            (clk),
      .reset          (reset),
      .fifo_not_empty (ne[g]),
      .fifo_data      (fd[g]),
      .fifo_shift_out (pop[g]),
      .tx             (tx[g]),
      .busy           (busy[g])
    );
  end

  // Random data on the FIFO output while it is empty
  always @(negedge clk) begin
    for (int g = 0; g < NL; g++) junk[g] <= 8'($urandom);
  end

  // 2-word FWFT FIFO model: one pop and at most one push per clock
  always @(posedge clk or negedge reset) begin
    int   c;
    logic r;
    if (!reset) begin
      for (int g = 0; g < NL; g++) begin
        fcnt[g]   <= 0;
        frd[g]    <= 1'b0;
        wr_idx[g] <= 0;
        pops[g]   <= 0;
      end
    end else begin
      for (int g = 0; g < NL; g++) begin
        c = fcnt[g];
        r = frd[g];
        if (pop[g]) begin
          pops[g] <= pops[g] + 1;
          if (c > 0) begin
            c = c - 1;
            r = ~r;
          end
        end
        if (wr_idx[g] < n_words[g] && cyc >= avail[g][wr_idx[g]] && c < 2) begin
          fmem[g][r ^ c[0]] <= words[g][wr_idx[g]];
          c = c + 1;
          wr_idx[g] <= wr_idx[g] + 1;
        end
        fcnt[g] <= c;
        frd[g]  <= r;
      end
    end
  end

  // UART decoder: tracks frame position by cycle offset, checks bit widths,
  // frame content, busy, pop latency and pop legality.
  always @(negedge clk) begin
    int         k, cpb, nb, par, pb;
    logic       started, act;
    logic [7:0] d;
    for (int g = 0; g < NL; g++) begin
      cpb = lane_clk(g);
      par = lane_par(g);
      nb  = 1 + 8 + ((par != 0) ? 1 : 0) + lane_stop(g);
      if (!reset) begin
        in_fr[g]    = 1'b0;
        off[g]      = 0;
        mon_idx[g]  = 0;
        busy_cnt[g] = 0;
        b2b[g]      = 0;
        just_end[g] = 1'b0;
        pop_pend[g] = 1'b0;
        pop_gap[g]  = 0;
        last_pop[g] = -1;
        check($sformatf("L%0d_rst_tx", g), 32'(tx[g]), 32'd1);
        check($sformatf("L%0d_rst_busy", g), 32'(busy[g]), 32'd0);
        check($sformatf("L%0d_rst_pop", g), 32'(pop[g]), 32'd0);
      end else begin
        started = 1'b0;
        if (in_fr[g]) begin
          off[g]++;
        end else if (tx[g] == 1'b0) begin
          in_fr[g] = 1'b1;
          off[g]   = 0;
          started  = 1'b1;
          if (just_end[g]) b2b[g]++;
        end
        just_end[g] = 1'b0;
        act = in_fr[g];
        if (busy[g]) busy_cnt[g]++;
        if (act) begin
          k = off[g] / cpb;
          if (off[g] % cpb == 0) bitv[g][k] = tx[g];
          else check($sformatf("L%0d_bitw", g), 32'(tx[g]), 32'(bitv[g][k]));
          if (off[g] == nb * cpb - 1) begin
            d = '0;
            for (int i = 0; i < 8; i++) d[i] = bitv[g][1 + i];
            check($sformatf("L%0d_startbit", g), 32'(bitv[g][0]), 32'd0);
            if (par != 0) begin
              pb = $countones(d) % 2;
              if (par == 1) pb = 1 - pb;
              check($sformatf("L%0d_parity", g), 32'(bitv[g][9]), 32'(pb));
              par_last[g] = bitv[g][9];
            end
            for (int s = 0; s < lane_stop(g); s++)
              check($sformatf("L%0d_stopbit", g), 32'(bitv[g][nb - 1 - s]), 32'd1);
            if (mon_idx[g] < n_words[g])
              check($sformatf("L%0d_data%0d", g, mon_idx[g]), 32'(d), 32'(words[g][mon_idx[g]]));
            else
              check($sformatf("L%0d_extra_frame", g), 32'(mon_idx[g]), 32'(n_words[g]));
            mon_idx[g]++;
            in_fr[g]    = 1'b0;
            just_end[g] = 1'b1;
          end
        end
        check($sformatf("L%0d_busy", g), 32'(busy[g]), 32'(act));
        if (pop_pend[g]) begin
          check($sformatf("L%0d_pop_lat_tx", g), 32'(tx[g]), 32'd0);
          check($sformatf("L%0d_pop_lat_start", g), 32'(started), 32'd1);
        end
        pop_pend[g] = pop[g];
        if (pop[g]) begin
          check($sformatf("L%0d_pop_nonempty", g), 32'(ne[g]), 32'd1);
          if (last_pop[g] >= 0) pop_gap[g] = cyc - last_pop[g];
          last_pop[g] = cyc;
        end
      end
    end
  end

  task automatic load(input int g, input logic [7:0] w, input int delay);
    words[g][n_words[g]] = w;
    avail[g][n_words[g]] = cyc + delay;
    n_words[g]++;
  endtask

  task automatic phase_reset();
    @(negedge clk);
    #2;
    reset = 1'b0;
    for (int g = 0; g < NL; g++) n_words[g] = 0;
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b1;
  endtask

  task automatic wait_done(input int g, input int nf, input int budget);
    int t;
    t = 0;
    while (!(mon_idx[g] >= nf && !busy[g] && !in_fr[g]) && t < budget) begin
      @(negedge clk);
      #1;
      t++;
    end
    check($sformatf("L%0d_timeout", g), 32'(t < budget), 32'd1);
  endtask

  initial begin
    int t, d0, d3;
    for (int g = 0; g < NL; g++) n_words[g] = 0;

    // Reset, then an empty FIFO for 100 clocks
    phase_reset();
    repeat (100) @(negedge clk);
    #1;
    for (int g = 0; g < NL; g++) begin
      check($sformatf("L%0d_idle_pops", g), 32'(pops[g]), 32'd0);
      check($sformatf("L%0d_idle_busy", g), 32'(busy_cnt[g]), 32'd0);
      check($sformatf("L%0d_idle_tx", g), 32'(tx[g]), 32'd1);
    end

    // Single byte 0x55
    phase_reset();
    load(0, 8'h55, 1);
    wait_done(0, 1, 200);
    check("t2_pops", 32'(pops[0]), 32'd1);
    check("t2_busy_clks", 32'(busy_cnt[0]), 32'd40);
    check("t2_frames", 32'(mon_idx[0]), 32'd1);

    // Two bytes available together: back-to-back frames
    phase_reset();
    load(0, 8'hA5, 1);
    load(0, 8'h3C, 1);
    wait_done(0, 2, 300);
    check("t3_pops", 32'(pops[0]), 32'd2);
    check("t3_pop_gap", 32'(pop_gap[0]), 32'd40);
    check("t3_busy_clks", 32'(busy_cnt[0]), 32'd80);
    check("t3_back_to_back", 32'(b2b[0]), 32'd1);

    // Parity and two stop bits on 0x07
    phase_reset();
    load(1, 8'h07, 1);
    load(2, 8'h07, 1);
    wait_done(1, 1, 200);
    wait_done(2, 1, 200);
    check("t4_even_par", 32'(par_last[1]), 32'd1);
    check("t4_odd_par", 32'(par_last[2]), 32'd0);
    check("t4_frame_even2stop", 32'(busy_cnt[1]), 32'd48);
    check("t4_frame_odd1stop", 32'(busy_cnt[2]), 32'd44);
    check("t4_pops1", 32'(pops[1]), 32'd1);
    check("t4_pops2", 32'(pops[2]), 32'd1);

    // Reset in the middle of a 0xFF frame, then a clean 0x81 frame
    phase_reset();
    load(0, 8'hFF, 1);
    t = 0;
    while (!(in_fr[0] && off[0] == 12) && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("t5_reach_clk13", 32'(t < 200), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    check("t5_async_tx", 32'(tx[0]), 32'd1);
    check("t5_async_busy", 32'(busy[0]), 32'd0);
    check("t5_async_pop", 32'(pop[0]), 32'd0);
    n_words[0] = 0;
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b1;
    load(0, 8'h81, 1);
    wait_done(0, 1, 200);
    check("t5_pops", 32'(pops[0]), 32'd1);
    check("t5_frames", 32'(mon_idx[0]), 32'd1);
    check("t5_busy_clks", 32'(busy_cnt[0]), 32'd40);

    // Random bytes and gaps on the fast lane and the 217-clock lane
    phase_reset();
    d0 = 1;
    for (int i = 0; i < 150; i++) begin
      d0 += $urandom_range(0, 60);
      load(0, 8'($urandom), d0);
    end
    d3 = 1;
    for (int i = 0; i < 10; i++) begin
      d3 += $urandom_range(0, 1500);
      load(3, 8'($urandom), d3);
    end
    wait_done(0, 150, 40000);
    wait_done(3, 10, 60000);
    check("t6_l0_pops", 32'(pops[0]), 32'd150);
    check("t6_l0_frames", 32'(mon_idx[0]), 32'd150);
    check("t6_l3_pops", 32'(pops[3]), 32'd10);
    check("t6_l3_frames", 32'(mon_idx[3]), 32'd10);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
